// File: rtl/emergency_preempt.sv
// Siren-input conditioner for the north-south light: synchronizes and debounces the raw
// detector, issues a fixed-length emergency request, then enforces a cooldown.
module emergency_preempt #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 1,
    parameter int COOLDOWN_CYCLES = 36
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       siren_raw,
    input  logic       clear_count,
    output logic       emergency,
    output logic       busy,
    output logic [7:0] preempt_count,
    output logic [1:0] dbg_state
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C = (MAX_A > COOLDOWN_CYCLES) ? MAX_A : COOLDOWN_CYCLES;
    localparam int CW    = (MAX_C < 2) ? 1 : $clog2(MAX_C + 1);

    localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(COOLDOWN_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUALIFY  = 2'd1,
        ASSERT   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_emergency;
    logic                   r_busy;
    logic [7:0]             r_count;
    logic                   w_siren_s;
    logic                   w_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], siren_raw};
        end
    end

    assign w_siren_s = r_sync[SYNC_STAGES-1];

    // Qualification completes on the D-th consecutive high cycle; with D=1 that is cycle 0 itself.
    assign w_fire = w_siren_s &&
                    (((r_state == IDLE) && (DEBOUNCE_CYCLES == 1)) ||
                     ((r_state == QUALIFY) && (r_cnt == D_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_emergency <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_fire) begin
            r_state     <= ASSERT;
            r_cnt       <= CNT_ONE;
            r_emergency <= 1'b1;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_siren_s) begin
                        r_state <= QUALIFY;
                        r_cnt   <= CNT_ONE;
                    end
                end
                QUALIFY: begin
                    if (!w_siren_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ASSERT: begin
                    if (r_cnt == H_LAST) begin
                        r_emergency <= 1'b0;
                        if (COOLDOWN_CYCLES == 0) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= COOLDOWN;
                            r_cnt   <= CNT_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (r_cnt == C_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_emergency <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // A clear on the same edge as an event leaves that event counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (clear_count) begin
            r_count <= w_fire ? 8'd1 : 8'd0;
        end else if (w_fire && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign emergency     = r_emergency;
    assign busy          = r_busy;
    assign preempt_count = r_count;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_emergency_preempt.sv
// Bench for emergency_preempt: a default instance and a D=1/H=3/C=0 instance share stimulus
// and are checked every cycle against a window-based behavioural model.
module tb_emergency_preempt;

    localparam int S = 2;

    logic       clk;
    logic       rst_n;
    logic       siren_raw;
    logic       clear_count;
    logic       emerg0, busy0, emerg1, busy1;
    logic [7:0] cnt0, cnt1;
    logic [1:0] dbg0, dbg1;

    int n_total = 0;
    int n_bad   = 0;

    // behavioural model: per instance, the emergency/busy windows of the last event
    int   md [2];
    int   mh [2];
    int   mc [2];
    int   m_cyc;
    int   m_run  [2];
    int   m_free [2];
    int   m_elo  [2];
    int   m_ehi  [2];
    int   m_bhi  [2];
    int   m_cnt  [2];
    logic m_pipe [S];
    logic prev_e0;

    logic [7:0] exp_q[$];

    emergency_preempt #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(1), .COOLDOWN_CYCLES(36)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .siren_raw(siren_raw), .clear_count(clear_count),
        .emergency(emerg0), .busy(busy0), .preempt_count(cnt0), .dbg_state(dbg0)
    );

    emergency_preempt #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(1), .HOLD_CYCLES(3), .COOLDOWN_CYCLES(0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .siren_raw(siren_raw), .clear_count(clear_count),
        .emergency(emerg1), .busy(busy1), .preempt_count(cnt1), .dbg_state(dbg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cyc = 0;
        for (int k = 0; k < S; k++) m_pipe[k] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = 0;
            m_free[i] = 0;
            m_elo[i]  = 1;
            m_ehi[i]  = 0;
            m_bhi[i]  = 0;
            m_cnt[i]  = 0;
        end
        exp_q.delete();
        prev_e0 = 1'b0;
    endtask

    function automatic bit m_will_fire(input int i);
        return (m_cyc >= m_free[i]) && m_pipe[S-1] && (m_run[i] + 1 == md[i]);
    endfunction

    // One clock edge of the model: the detector sees the synchronized siren of the ending cycle.
    task automatic m_edge(input logic raw, input logic clr);
        logic ss;
        bit   fired;
        ss = m_pipe[S-1];
        for (int i = 0; i < 2; i++) begin
            fired = 0;
            if (m_cyc >= m_free[i]) begin
                m_run[i] = ss ? m_run[i] + 1 : 0;
                if (m_run[i] == md[i]) begin
                    m_elo[i]  = m_cyc + 1;
                    m_ehi[i]  = m_cyc + mh[i];
                    m_bhi[i]  = m_cyc + mh[i] + mc[i];
                    m_free[i] = m_cyc + mh[i] + mc[i] + 1;
                    m_run[i]  = 0;
                    fired     = 1;
                end
            end
            if (fired) m_cnt[i] = clr ? 1 : ((m_cnt[i] < 255) ? m_cnt[i] + 1 : 255);
            else if (clr) m_cnt[i] = 0;
            if (fired && i == 0) exp_q.push_back(8'(m_cnt[0]));
        end
        for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = raw;
        m_cyc++;
    endtask

    function automatic int m_emerg(input int i);
        return (m_cyc >= m_elo[i] && m_cyc <= m_ehi[i]) ? 1 : 0;
    endfunction

    function automatic int m_busy(input int i);
        return (m_cyc >= m_elo[i] && m_cyc <= m_bhi[i]) ? 1 : 0;
    endfunction

    task automatic compare();
        logic [7:0] e;
        chk("emerg0", int'(emerg0), m_emerg(0));
        chk("busy0",  int'(busy0),  m_busy(0));
        chk("count0", int'(cnt0),   m_cnt[0]);
        chk("emerg1", int'(emerg1), m_emerg(1));
        chk("busy1",  int'(busy1),  m_busy(1));
        chk("count1", int'(cnt1),   m_cnt[1]);
        if (emerg0 && !prev_e0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("event_count", int'(cnt0), int'(e));
            end
        end
        prev_e0 = emerg0;
    endtask

    // Drive at the falling edge, model the rising edge, observe at the next falling edge.
    task automatic step(input logic raw, input logic clr);
        siren_raw   = raw;
        clear_count = clr;
        @(posedge clk);
        if (rst_n) m_edge(raw, clr);
        else m_reset();
        @(negedge clk);
        compare();
    endtask

    initial begin
        int  n, hi, nh;
        bit  found;
        int  rises[$];
        int  e0_run, b0_run, e1_run, g1_run;
        bit  e1_seen, pe0;
        logic cur_raw;
        int  run_left;

        md[0] = 4; mh[0] = 1; mc[0] = 36;
        md[1] = 1; mh[1] = 3; mc[1] = 0;
        rst_n = 1'b0;
        siren_raw = 1'b0;
        clear_count = 1'b0;
        m_reset();
        @(negedge clk);

        // reset holds everything low even with the siren active
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0);
            chk("state_idle_rst", int'(dbg0), 0);
        end
        rst_n = 1'b1;
        found = 0;
        n = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step(1'b1, 1'b0);
            if (emerg0) begin
                found = 1;
                n = k;
            end
        end
        chk("rst_latency_in_range", int'(found && n >= 5 && n <= 7), 1);
        repeat (60) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);

        // glitch rejection then a qualifying burst
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        chk("glitch_count", int'(cnt0), 0);
        hi = 0;
        for (int k = 0; k < 14; k++) begin
            step(k < 4, 1'b0);
            hi += int'(emerg0);
        end
        chk("qual_pulse_cycles", hi, 1);
        chk("qual_count", int'(cnt0), 1);
        repeat (50) step(1'b0, 1'b0);

        // siren held high: pulse spacing, widths, busy length, and the D=1/C=0 instance pattern
        e0_run = 0; b0_run = 0; e1_run = 0; g1_run = 0; e1_seen = 0; pe0 = 0;
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 1'b0);
            if (emerg0 && !pe0) rises.push_back(m_cyc);
            pe0 = emerg0;
            if (emerg0) e0_run++;
            else if (e0_run > 0) begin chk("pulse_width", e0_run, 1); e0_run = 0; end
            if (busy0) b0_run++;
            else if (b0_run > 0) begin chk("busy_len", b0_run, 37); b0_run = 0; end
            if (emerg1) begin
                if (e1_seen && g1_run > 0) chk("sweep_gap", g1_run, 1);
                g1_run = 0;
                e1_run++;
                e1_seen = 1;
            end else begin
                if (e1_run > 0) chk("sweep_width", e1_run, 3);
                e1_run = 0;
                if (e1_seen) g1_run++;
            end
        end
        chk("pulse_count_ok", int'(rises.size() == 2 || rises.size() == 3), 1);
        for (int k = 1; k < rises.size(); k++) chk("pulse_spacing", rises[k] - rises[k-1], 41);
        repeat (60) step(1'b0, 1'b0);

        // asynchronous reset while emergency is high
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b1, 1'b0);
            if (emerg0) found = 1;
        end
        chk("emerg_seen_before_reset", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_emerg", int'(emerg0), 0);
        chk("async_busy", int'(busy0), 0);
        chk("async_state", int'(dbg0), 0);
        chk("async_count", int'(cnt0), 0);
        m_reset();
        repeat (3) step(1'b0, 1'b0);
        rst_n = 1'b1;
        nh = 0;
        repeat (60) begin
            step(1'b0, 1'b0);
            nh += int'(emerg0);
        end
        chk("no_pulse_after_reset", nh, 0);

        // saturation and clear interaction
        for (int k = 0; k < 12000 && m_cnt[0] < 255; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 100 && !m_will_fire(0); k++) step(1'b1, 1'b0);
        chk("fire_predicted_a", int'(m_will_fire(0)), 1);
        step(1'b1, 1'b0);
        chk("count_saturated", int'(cnt0), 255);
        for (int k = 0; k < 100 && !m_will_fire(0); k++) step(1'b1, 1'b0);
        chk("fire_predicted_b", int'(m_will_fire(0)), 1);
        step(1'b1, 1'b1);
        chk("clear_with_event", int'(cnt0), 1);
        repeat (60) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("clear_alone0", int'(cnt0), 0);
        chk("clear_alone1", int'(cnt1), 0);

        // randomized bursts, occasional clears and resets
        run_left = 0;
        cur_raw = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (run_left == 0) begin
                cur_raw  = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 9);
            end
            run_left--;
            step(cur_raw, 1'($urandom_range(0, 40) == 0));
            if ($urandom_range(0, 600) == 0) begin
                rst_n = 1'b0;
                step(cur_raw, 1'b0);
                step(cur_raw, 1'b0);
                rst_n = 1'b1;
            end
        end
        repeat (50) step(1'b0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
